// File: rtl/mux_round_robin_arbiter_if.sv
// Bus between the round-robin arbiter and its four requesters / the 4:1 mux.
//   req      : request vector, req[i] high = requester i wants the mux
//   grant    : one-hot grant, all zero when idle
//   address0 : mux select LSB (owner index bit 0)
//   address1 : mux select MSB (owner index bit 1)
//   active   : high while any grant is asserted
//   preempt  : one-cycle pulse when a grant switches because of a hold timeout
// master = arbiter side, slave = requester / mux side.
interface mux_round_robin_arbiter_if;
   logic [3:0] req;
   logic [3:0] grant;
   logic       address0;
   logic       address1;
   logic       active;
   logic       preempt;

   modport master (
      input  req,
      output grant, address0, address1, active, preempt
   );

   modport slave (
      output req,
      input  grant, address0, address1, active, preempt
   );
endinterface

// File: rtl/mux_round_robin_arbiter.sv
// Round-robin arbiter sharing one 4:1 single-bit mux between four requesters.
// An owner keeps the mux while its request stays high, up to MAX_HOLD
// consecutive cycles, after which it is preempted by the next waiting
// requester. Select lines are registered and change only with the grant.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : arbiter bus (req in; grant, address0/1, active, preempt out)
module mux_round_robin_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   mux_round_robin_arbiter_if.master       bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state;
   logic [1:0] owner;
   logic [1:0] last;
   logic [7:0] hold_cnt;
   logic [3:0] grant;
   logic       preempt;

   logic [2:0] idle_pick;
   logic [2:0] rel_pick;
   logic [2:0] to_pick;

   // Returns {found, index} of the first set bit of r, scanning from start
   // upward and wrapping 3 -> 0.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
      logic [2:0] res;
      logic [1:0] idx;
      res = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = start + 2'(i);
         if (!res[2] && r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb begin
      idle_pick = rr_pick(bus.req, last + 2'd1);
      rel_pick  = rr_pick(bus.req, owner + 2'd1);
      // On timeout the current owner is masked out so it cannot win again.
      to_pick   = rr_pick(bus.req & ~(4'b0001 << owner), owner + 2'd1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= '0;
         last     <= 2'd3;
         hold_cnt <= '0;
         grant    <= '0;
         preempt  <= 1'b0;
      end else begin
         preempt <= 1'b0;
         case (state)
            IDLE: begin
               if (idle_pick[2]) begin
                  grant    <= 4'b0001 << idle_pick[1:0];
                  owner    <= idle_pick[1:0];
                  last     <= idle_pick[1:0];
                  hold_cnt <= '0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (!bus.req[owner]) begin
                  hold_cnt <= '0;
                  if (rel_pick[2]) begin
                     grant <= 4'b0001 << rel_pick[1:0];
                     owner <= rel_pick[1:0];
                     last  <= rel_pick[1:0];
                  end else begin
                     grant <= '0;
                     state <= IDLE;
                  end
               end else if (hold_cnt == HOLD_LAST) begin
                  hold_cnt <= '0;
                  if (to_pick[2]) begin
                     grant   <= 4'b0001 << to_pick[1:0];
                     owner   <= to_pick[1:0];
                     last    <= to_pick[1:0];
                     preempt <= 1'b1;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

   assign bus.grant    = grant;
   assign bus.address0 = owner[0];
   assign bus.address1 = owner[1];
   assign bus.active   = |grant;
   assign bus.preempt  = preempt;

endmodule

// File: tb/tb_mux_round_robin_arbiter.sv
// Directed bench for mux_round_robin_arbiter. Observed vector per check is
// {preempt, active, address1, address0, grant[3:0]}.
module tb_mux_round_robin_arbiter;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mux_round_robin_arbiter_if if8 ();
   mux_round_robin_arbiter_if if1 ();

   mux_round_robin_arbiter #(.MAX_HOLD(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (if8.master)
   );

   mux_round_robin_arbiter #(.MAX_HOLD(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] obs8();
      return {if8.preempt, if8.active, if8.address1, if8.address0, if8.grant};
   endfunction

   function automatic logic [7:0] obs1();
      return {if1.preempt, if1.active, if1.address1, if1.address0, if1.grant};
   endfunction

   initial begin
      logic [7:0] exp;
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      if8.req = 4'b0000;
      if1.req = 4'b0000;

      // 1: reset state, single request, release
      @(negedge clk);
      check_eq("reset_state", obs8(), 8'b0000_0000);
      reset = 1'b0;
      if8.req = 4'b0001;
      @(negedge clk);
      check_eq("t1_grant0", obs8(), 8'b0100_0001);
      if8.req = 4'b0000;
      @(negedge clk);
      check_eq("t1_idle", obs8(), 8'b0000_0000);

      // 2: full rotation with MAX_HOLD=8
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      if8.req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp = {(c == 0 && k != 0) ? 1'b1 : 1'b0, 1'b1, 2'(k), 4'(1 << k)};
            check_eq($sformatf("t2_rot_k%0d_c%0d", k, c), obs8(), exp);
         end
      end
      @(negedge clk);
      check_eq("t2_wrap", obs8(), 8'b1100_0001);

      // 3: owner 1 releases, handoff to 2 with no idle cycle
      for (int c = 0; c < 7; c++) @(negedge clk);
      @(negedge clk);
      check_eq("t3_owner1", obs8(), 8'b1101_0010);
      if8.req = 4'b1101;
      @(negedge clk);
      check_eq("t3_handoff", obs8(), 8'b0110_0100);

      // 4: sole requester keeps the mux past the limit
      if8.req = 4'b0100;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check_eq($sformatf("t4_sole_c%0d", c), obs8(), 8'b0110_0100);
      end

      // 5: async reset mid-grant
      if8.req = 4'b1000;
      @(negedge clk);
      check_eq("t5_grant3", obs8(), 8'b0111_1000);
      #2 reset = 1'b1;
      #1 check_eq("t5_async_clear", obs8(), 8'b0000_0000);
      @(negedge clk);
      reset = 1'b0;
      if8.req = 4'b1001;
      @(negedge clk);
      check_eq("t5_restart", obs8(), 8'b0100_0001);
      if8.req = 4'b0000;

      // 6: MAX_HOLD=1 alternates every cycle
      if1.req = 4'b1010;
      @(negedge clk);
      check_eq("t6_first", obs1(), 8'b0101_0010);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         exp = (c % 2 == 0) ? 8'b1111_1000 : 8'b1101_0010;
         check_eq($sformatf("t6_alt_c%0d", c), obs1(), exp);
      end
      if1.req = 4'b0000;
      @(negedge clk);
      check_eq("t6_idle", obs1(), 8'b0011_0000 & 8'b0000_0000 | {4'b0001, 4'b0000});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
